mix_pipe: RTL and testbench

- Pipelined, multi-lane successor to the single-cycle 64-bit add mix.
- Per lane it computes the full Threefish-style MIX: y0 = x0 + x1, y1 = rotl(x1, R) ^ y0.
- R is a per-transaction rotation amount supplied with the data.
- Sits between the key-schedule/round controller and the permute stage; valid/ready streaming with full backpressure.

---
 rtl/mix_pkg.sv | 25 ++
 rtl/mix_lane.sv | 52 +++++
 rtl/mix_pipe.sv | 142 ++++++++++++++
 tb/tb_mix_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared constants and helpers for the multi-lane MIX pipeline.
// Rotations run at a wide fixed width with a runtime width argument so any lane width can share them.
package mix_pkg;

    localparam int MIX_W    = 64;
    localparam int MIX_WMAX = 512;

    function automatic logic [MIX_WMAX-1:0] rotl(input logic [MIX_WMAX-1:0] x, input int r, input int w);
        int s;
        logic [MIX_WMAX-1:0] m;
        s = r % w;
        m = (w >= MIX_WMAX) ? '1 : ((MIX_WMAX'(1) << w) - MIX_WMAX'(1));
        // x >> w is zero for s == 0, so R = 0 passes x through
        return ((x << s) | (x >> (w - s))) & m;
    endfunction

    function automatic logic [MIX_WMAX-1:0] rotr(input logic [MIX_WMAX-1:0] x, input int r, input int w);
        return rotl(x, (w - (r % w)) % w, w);
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mix_lane.sv
// Combinational per-lane MIX datapath, split into stage A (a, b) and stage B (y0, y1).
// Inverse MIX is built only when MIX_PIPE_INV_EN is defined.
module mix_lane
    import mix_pkg::*;
#(
    parameter int W = MIX_W
) (
    input  logic [W-1:0]         x0,
    input  logic [W-1:0]         x1,
    input  logic [$clog2(W)-1:0] rot,
    input  logic                 inv,
    output logic [W-1:0]         a,
    output logic [W-1:0]         b,
    input  logic [W-1:0]         a_in,
    input  logic [W-1:0]         b_in,
    input  logic                 inv_in,
    output logic [W-1:0]         y0,
    output logic [W-1:0]         y1
);

`ifdef MIX_PIPE_INV_EN
    // Inverse: a carries y0 and b recovers x1, so stage B only subtracts
    always_comb begin
        if (inv) begin
            a = x0;
            b = W'(rotr(MIX_WMAX'(x1 ^ x0), int'(rot), W));
        end else begin
            a = x0 + x1;
            b = W'(rotl(MIX_WMAX'(x1), int'(rot), W));
        end
    end

    always_comb begin
        if (inv_in) begin
            y0 = a_in - b_in;
            y1 = b_in;
        end else begin
            y0 = a_in;
            y1 = a_in ^ b_in;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv ^ inv_in;

    assign a  = x0 + x1;
    assign b  = W'(rotl(MIX_WMAX'(x1), int'(rot), W));
    assign y0 = a_in;
    assign y1 = a_in ^ b_in;
`endif

endmodule

// File: rtl/mix_pipe.sv
// Multi-lane pipelined Threefish MIX with valid/ready flow control and collapsing bubbles.
// Optional inverse mode is enabled by defining MIX_PIPE_INV_EN.
module mix_pipe
    import mix_pkg::*;
#(
    parameter int W     = MIX_W,
    parameter int LANES = 2,
    parameter int PIPE  = 2,
    localparam int RW   = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*W-1:0]  in_x0,
    input  logic [LANES*W-1:0]  in_x1,
    input  logic [LANES*RW-1:0] in_rot,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*W-1:0]  out_y0,
    output logic [LANES*W-1:0]  out_y1,
    output logic                busy
);

    logic [PIPE-1:0] vld_q, vld_d;
    logic [PIPE-1:0] rdy;
    logic [PIPE-1:0] take;
    logic            inv_eff;
    logic            inv_s;
    logic [LANES-1:0][W-1:0] a_c, b_c, a_s, b_s, y0_c, y1_c;
    logic [LANES-1:0][W-1:0] y0_q, y0_d, y1_q, y1_d;

`ifdef MIX_PIPE_INV_EN
    assign inv_eff = in_inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_eff       = 1'b0;
`endif

    // A stage may load when it is empty or everything downstream of it advances
    always_comb begin : rdy_chain
        logic r;
        r = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            r      = !vld_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        take     = '0;
        vld_d    = vld_q;
        take[0]  = in_valid && rdy[0];
        vld_d[0] = rdy[0] ? in_valid : vld_q[0];
        for (int k = 1; k < PIPE; k++) begin
            take[k]  = vld_q[k-1] && rdy[k];
            vld_d[k] = rdy[k] ? vld_q[k-1] : vld_q[k];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mix_lane #(.W(W)) u_lane (
            .x0     (in_x0[lane_lo(i, W) +: W]),
            .x1     (in_x1[lane_lo(i, W) +: W]),
            .rot    (in_rot[lane_lo(i, RW) +: RW]),
            .inv    (inv_eff),
            .a      (a_c[i]),
            .b      (b_c[i]),
            .a_in   (a_s[i]),
            .b_in   (b_s[i]),
            .inv_in (inv_s),
            .y0     (y0_c[i]),
            .y1     (y1_c[i])
        );
    end

    if (PIPE == 2) begin : g_two
        logic [LANES-1:0][W-1:0] a_q, a_d, b_q, b_d;
        logic                    inv_q, inv_d;

        always_comb begin
            a_d   = a_q;
            b_d   = b_q;
            inv_d = inv_q;
            if (take[0]) begin
                a_d   = a_c;
                b_d   = b_c;
                inv_d = inv_eff;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q   <= '0;
                b_q   <= '0;
                inv_q <= 1'b0;
            end else begin
                a_q   <= a_d;
                b_q   <= b_d;
                inv_q <= inv_d;
            end
        end

        assign a_s   = a_q;
        assign b_s   = b_q;
        assign inv_s = inv_q;
    end else begin : g_one
        assign a_s   = a_c;
        assign b_s   = b_c;
        assign inv_s = inv_eff;
    end

    always_comb begin
        y0_d = y0_q;
        y1_d = y1_q;
        if (take[PIPE-1]) begin
            y0_d = y0_c;
            y1_d = y1_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
        end else begin
            vld_q <= vld_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
        end
    end

    assign in_ready  = rdy[0] && !rst;
    assign out_valid = vld_q[PIPE-1];
    assign busy      = |vld_q;
    assign out_y0    = y0_q;
    assign out_y1    = y1_q;

endmodule

// File: tb/tb_mix_pipe.sv
// Randomized self-checking bench for mix_pipe against a queue-based behavioural model.
module tb_mix_pipe;

    localparam int W     = 64;
    localparam int LANES = 2;
    localparam int PIPE  = 2;
    localparam int RW    = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready, in_inv;
    logic [LANES*W-1:0]  in_x0, in_x1;
    logic [LANES*RW-1:0] in_rot;
    logic                out_valid, out_ready, busy;
    logic [LANES*W-1:0]  out_y0, out_y1;

    mix_pipe #(.W(W), .LANES(LANES), .PIPE(PIPE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_rot(in_rot), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 acc;
        logic [LANES*W-1:0] y0;
        logic [LANES*W-1:0] y1;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LANES*W-1:0] act, input logic [LANES*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] rl(input logic [63:0] x, input int r);
        int s;
        s = r % 64;
        return (s == 0) ? x : ((x << s) | (x >> (64 - s)));
    endfunction

    // Reference MIX straight from the math: y0 = x0 + x1, y1 = rotl(x1,R) ^ y0, inverse undoes it
    task automatic model(input logic [LANES*W-1:0] x0, input logic [LANES*W-1:0] x1,
                         input logic [LANES*RW-1:0] rot, input logic inv,
                         output logic [LANES*W-1:0] y0, output logic [LANES*W-1:0] y1);
        logic [63:0] a, b, t;
        int r;
        for (int l = 0; l < LANES; l++) begin
            a = x0[l*W +: W];
            b = x1[l*W +: W];
            r = int'(rot[l*RW +: RW]);
            if (!inv) begin
                y0[l*W +: W] = a + b;
                y1[l*W +: W] = rl(b, r) ^ (a + b);
            end else begin
                t = rl(b ^ a, (64 - r) % 64);
                y0[l*W +: W] = a - t;
                y1[l*W +: W] = t;
            end
        end
    endtask

    int                 n;
    logic               ev, inv_eff;
    exp_t               e;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            q.delete();
        end else begin
            n = q.size();
            chk("in_ready", in_ready, (n < PIPE) || out_ready);
            chk("busy", busy, n > 0);
            ev = (n > 0) && (cyc - q[0].acc >= PIPE);
            chk("out_valid", out_valid, ev);
            if (ev && out_valid) begin
                chk("out_y0", out_y0, q[0].y0);
                chk("out_y1", out_y1, q[0].y1);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
`ifdef MIX_PIPE_INV_EN
                inv_eff = in_inv;
`else
                inv_eff = 1'b0;
`endif
                e.acc = cyc;
                model(in_x0, in_x1, in_rot, inv_eff, e.y0, e.y1);
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                        input logic [LANES*RW-1:0] r, input logic inv);
        int   g;
        logic acc;
        in_x0 = a; in_x1 = b; in_rot = r; in_inv = inv; in_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", g);
        end
    endtask

    task automatic idle(input int c);
        in_valid = 1'b0;
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [LANES*W-1:0] rnd_word();
        logic [LANES*W-1:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) v = '1;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [LANES*W-1:0] my0, my1, ry0, ry1, xa, xb;
    logic [LANES*RW-1:0] rr;
    logic acc_r;
    int   g;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
        in_x0 = '0; in_x1 = '0; in_rot = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_y0", out_y0, '0);
        chk("reset_y1", out_y1, '0);
        @(posedge clk); #1;

        // Directed vectors pin the model to hand-computed results
        model({64'h0, 64'h1}, {64'h0, 64'h8000000000000000}, {6'd0, 6'd1}, 1'b0, my0, my1);
        chk("pin_basic_y0", my0, {64'h0, 64'h8000000000000001});
        chk("pin_basic_y1", my1, {64'h0, 64'h8000000000000000});
        model({64'h2, 64'hFFFFFFFFFFFFFFFF}, {64'h3, 64'h1}, {6'd63, 6'd0}, 1'b0, my0, my1);
        chk("pin_wrap_y0", my0, {64'h5, 64'h0});
        chk("pin_wrap_y1", my1, {64'h8000000000000004, 64'h1});

        send({64'h0, 64'h1}, {64'h0, 64'h8000000000000000}, {6'd0, 6'd1}, 1'b0);
        send({64'h2, 64'hFFFFFFFFFFFFFFFF}, {64'h3, 64'h1}, {6'd63, 6'd0}, 1'b0);
        idle(4);

        // Backpressure: 6 back-to-back with the output stalled for 4 cycles
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(rnd_word(), rnd_word(), LANES*RW'($urandom()), 1'b0);
                idle(0);
            end
            begin
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(8);

        // Reset with two transactions held in the pipe
        out_ready = 1'b0;
        send(rnd_word(), rnd_word(), LANES*RW'($urandom()), 1'b0);
        send(rnd_word(), rnd_word(), LANES*RW'($urandom()), 1'b0);
        idle(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_y0", out_y0, '0);
        @(posedge clk); #1;
        idle(4);

        // Random traffic with random backpressure
        acc_r = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc_r) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_x0    = rnd_word();
                in_x1    = rnd_word();
                in_rot   = LANES*RW'($urandom());
`ifdef MIX_PIPE_INV_EN
                in_inv   = $urandom_range(0, 1) == 1;
`endif
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc_r = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        idle(0);
        out_ready = 1'b1;
        in_inv = 1'b0;

`ifdef MIX_PIPE_INV_EN
        // Round trip: forward then inverse of the forward result, alternating every cycle
        for (int i = 0; i < 200; i++) begin
            xa = rnd_word();
            xb = rnd_word();
            rr = {6'($urandom_range(0, 63)), 6'(i % 64)};
            model(xa, xb, rr, 1'b0, ry0, ry1);
            model(ry0, ry1, rr, 1'b1, my0, my1);
            chk("pin_roundtrip_x0", my0, xa);
            chk("pin_roundtrip_x1", my1, xb);
            send(xa, xb, rr, 1'b0);
            send(ry0, ry1, rr, 1'b1);
        end
        idle(0);
        in_inv = 1'b0;
`endif

        g = 0;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_empty", 128'(q.size()), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
